// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned NChDefault = 8;

  // Alignment state: hunting for a frame marker, or locked to the frame.
  typedef enum logic {
    StHunt = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: wraps naturally at 2**SelW.
// Control priority: clear, then load-to-1, then increment.
module tdm_slot_ctr #(
  parameter int unsigned SelW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            load1_i,
  input  logic            inc_i,
  output logic [SelW-1:0] cnt_o
);

  logic [SelW-1:0] cnt_q, cnt_d;

  // Next count from the prioritised controls.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = SelW'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + SelW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux8.sv
// 8-channel TDM demultiplexer: steers serial beats into per-slot hold bits and
// publishes each complete frame with a one-cycle frame_valid pulse.
// Optional framing checks are enabled with the TDM_SYNC_CHECK_EN macro.
module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter  int unsigned N_CH  = NChDefault,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  q,
  output logic [N_CH-1:0]  frame,
  output logic             frame_valid,
  output logic             sync_err
);

  state_e           state_q;
  logic [N_CH-1:0]  q_q;
  logic [N_CH-1:0]  frame_q;
  logic             frame_valid_q;
  logic [SEL_W-1:0] sel_q;

  logic ctr_clr, ctr_load1, ctr_inc;
  logic accept;
  logic last_slot;
  logic realign, lose_sync;

  tdm_slot_ctr #(
    .SelW (SEL_W)
  ) u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load1),
    .inc_i   (ctr_inc),
    .cnt_o   (sel_q)
  );

  assign last_slot = (sel_q == SEL_W'(N_CH - 1));

  // Classify the current beat and derive the slot counter controls.
  always_comb begin
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;
    accept    = 1'b0;
    realign   = 1'b0;
    lose_sync = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          // Only a marked beat can start a frame; everything else is dropped.
          if (frame_sync) begin
            ctr_load1 = 1'b1;
          end
        end
        StRun: begin
`ifdef TDM_SYNC_CHECK_EN
          if (frame_sync && (sel_q != '0)) begin
            // Early marker: drop the partial frame and restart at slot 0.
            realign   = 1'b1;
            ctr_load1 = 1'b1;
          end else if (!frame_sync && (sel_q == '0)) begin
            // Missing marker: alignment lost, drop the bit.
            lose_sync = 1'b1;
            ctr_clr   = 1'b1;
          end else begin
            accept  = 1'b1;
            ctr_inc = 1'b1;
          end
`else
          accept  = 1'b1;
          ctr_inc = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef TDM_SYNC_CHECK_EN
  logic sync_err_q;
`endif

  // Alignment FSM, hold/frame registers and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      q_q           <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
      sync_err_q    <= 1'b0;
`endif
    end else begin
      frame_valid_q <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
      sync_err_q    <= realign | lose_sync;
      if (lose_sync) begin
        state_q <= StHunt;
      end
`endif
      // Slot-0 write for both frame start from HUNT and realignment.
      if (ctr_load1) begin
        q_q[0]  <= din;
        state_q <= StRun;
      end
      if (accept) begin
        q_q[sel_q] <= din;
        if (last_slot) begin
          // The final bit bypasses q so the frame is complete this edge.
          frame_q       <= {din, q_q[N_CH-2:0]};
          frame_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef TDM_SYNC_CHECK_EN
  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign sel         = sel_q;
  assign q           = q_q;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [2:0] sel;
  logic [7:0] q;
  logic [7:0] frame;
  logic       frame_valid;
  logic       sync_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_last = 0;
  int fv_prev = 0;
  int t0 = 0;
  int base = 0;
  logic [7:0] pat;

  tdm_demux8 #(
    .N_CH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .sel         (sel),
    .q           (q),
    .frame       (frame),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts every sampled frame_valid cycle and its timing.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt  <= fv_cnt + 1;
      fv_prev <= fv_last;
      fv_last <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    din        = d;
    frame_sync = s;
    din_valid  = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    din        = 1'b0;
    frame_sync = 1'b0;
    din_valid  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      beat(f[i], (i == 0));
      if (i == 0) t0 = cyc;
      if (gaps && (i == 2 || i == 5)) begin
        idle();
        idle();
      end
    end
  endtask

  initial begin
    // Reset
    idle();
    idle();
    rst = 1'b0;
    check_eq("rst_sel", 8'(sel), 8'h00);
    check_eq("rst_q", q, 8'h00);
    check_eq("rst_frame", frame, 8'h00);
    check_eq("rst_fv", 8'(frame_valid), 8'h00);
    check_eq("rst_serr", 8'(sync_err), 8'h00);

    // HUNT drops unmarked beats
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    idle();
    check_eq("hunt_q", q, 8'h00);
    check_eq("hunt_sel", 8'(sel), 8'h00);
    idle();
    check_eq("hunt_fvcnt", 8'(fv_cnt), 8'h00);

    // Back-to-back frame A6
    base = fv_cnt;
    send_frame(8'hA6, 1'b0);
    idle();
    check_eq("b2b_fv", 8'(frame_valid), 8'h01);
    check_eq("b2b_frame", frame, 8'hA6);
    check_eq("b2b_q", q, 8'hA6);
    check_eq("b2b_sel", 8'(sel), 8'h00);
    idle();
    check_eq("b2b_fv_drop", 8'(frame_valid), 8'h00);
    idle();
    check_eq("b2b_pulses", 8'(fv_cnt - base), 8'h01);
    check_eq("b2b_latency", 8'(fv_last - t0), 8'd8);

    // Same frame with two 2-cycle gaps
    base = fv_cnt;
    send_frame(8'hA6, 1'b1);
    idle();
    check_eq("gap_fv", 8'(frame_valid), 8'h01);
    check_eq("gap_frame", frame, 8'hA6);
    idle();
    idle();
    check_eq("gap_pulses", 8'(fv_cnt - base), 8'h01);
    check_eq("gap_latency", 8'(fv_last - t0), 8'd12);

    // Two consecutive frames
    base = fv_cnt;
    send_frame(8'hA6, 1'b0);
    send_frame(8'h3C, 1'b0);
    idle();
    check_eq("two_frame", frame, 8'h3C);
    check_eq("two_q", q, 8'h3C);
    idle();
    idle();
    check_eq("two_pulses", 8'(fv_cnt - base), 8'h02);
    check_eq("two_spacing", 8'(fv_last - fv_prev), 8'd8);

    // Reset in the middle of a frame
    pat = 8'hA6;
    for (int i = 0; i < 5; i++) beat(pat[i], (i == 0));
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check_eq("mrst_sel", 8'(sel), 8'h00);
    check_eq("mrst_q", q, 8'h00);
    check_eq("mrst_frame", frame, 8'h00);
    check_eq("mrst_fv", 8'(frame_valid), 8'h00);
    send_frame(8'hFF, 1'b0);
    idle();
    check_eq("ff_frame", frame, 8'hFF);
    check_eq("ff_q", q, 8'hFF);
    check_eq("ff_fv", 8'(frame_valid), 8'h01);

    // Marker arriving at slot 3
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b1);
    idle();
`ifdef TDM_SYNC_CHECK_EN
    check_eq("sc_serr", 8'(sync_err), 8'h01);
    check_eq("sc_sel", 8'(sel), 8'h01);
    idle();
    check_eq("sc_serr_drop", 8'(sync_err), 8'h00);
    base = fv_cnt;
    pat = 8'h2A;  // slots 1..7 = 0,1,0,1,0,1,0
    for (int i = 0; i < 7; i++) beat(pat[i], 1'b0);
    idle();
    check_eq("sc_fv", 8'(frame_valid), 8'h01);
    check_eq("sc_frame", frame, 8'h55);
    check_eq("sc_q", q, 8'h55);
    check_eq("sc_sel_end", 8'(sel), 8'h00);
    idle();
    check_eq("sc_pulses", 8'(fv_cnt - base), 8'h01);
`else
    check_eq("nc_serr", 8'(sync_err), 8'h00);
    check_eq("nc_sel", 8'(sel), 8'h04);
    pat = 8'h0A;  // slots 4..7 = 0,1,0,1
    for (int i = 0; i < 4; i++) beat(pat[i], 1'b0);
    idle();
    check_eq("nc_fv", 8'(frame_valid), 8'h01);
    check_eq("nc_frame", frame, 8'hAB);
    check_eq("nc_sel_wrap", 8'(sel), 8'h00);
    pat = 8'h02;  // slots 0..2 = 0,1,0
    for (int i = 0; i < 3; i++) beat(pat[i], 1'b0);
    idle();
    check_eq("nc_sel_end", 8'(sel), 8'h03);
    check_eq("nc_q", q, 8'hAA);
    check_eq("nc_serr_end", 8'(sync_err), 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
